// File: rtl/sipo_block_assembler_if.sv
// Byte-in / block-out bus of the receive-side SIPO block assembler.
// slave is the assembler's view; master is the driver (UART RX side plus AES core).
interface sipo_block_assembler_if;
  logic [7:0]   byte_in;
  logic         byte_valid;
  logic         flush;
  logic         block_ready;
  logic         clr_overrun;
  logic [127:0] block_out;
  logic         block_valid;
  logic [4:0]   byte_count;
  logic         busy;
  logic         overrun;
  logic         timeout;

  modport slave (
    input  byte_in, byte_valid, flush, block_ready, clr_overrun,
    output block_out, block_valid, byte_count, busy, overrun, timeout
  );

  modport master (
    output byte_in, byte_valid, flush, block_ready, clr_overrun,
    input  block_out, block_valid, byte_count, busy, overrun, timeout
  );
endinterface

// File: rtl/sipo_block_assembler.sv
// Packs 16 UART bytes MSB-first into a 128-bit block with a valid/ready output.
// Optional idle timeout for partial blocks is enabled with macro SIPO_TIMEOUT_EN.
module sipo_block_assembler #(
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input logic                  clk,
  input logic                  reset,
  sipo_block_assembler_if.slave bus
);

  typedef enum logic [0:0] {StCollect, StHold} state_e;

  state_e       state_q, state_d;
  logic [119:0] shift_q, shift_d;
  logic [127:0] block_q, block_d;
  logic         valid_q, valid_d;
  logic [4:0]   count_q, count_d;
  logic         overrun_q, overrun_d;

`ifdef SIPO_TIMEOUT_EN
  localparam int unsigned IdleW = $clog2(TIMEOUT_CYCLES + 1);
  // Terminal value: the cycle in which this count is seen is the last idle cycle allowed.
  localparam logic [IdleW-1:0] IdleLast = IdleW'(TIMEOUT_CYCLES - 1);

  logic [IdleW-1:0] idle_q, idle_d;
  logic             timeout_q, timeout_d;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    block_d   = block_q;
    valid_d   = valid_q;
    count_d   = count_q;
    overrun_d = overrun_q & ~bus.clr_overrun;
`ifdef SIPO_TIMEOUT_EN
    idle_d    = '0;
    timeout_d = 1'b0;
`endif

    unique case (state_q)
      StCollect: begin
        if (bus.flush) begin
          count_d = 5'd0;
          shift_d = '0;
        end else if (bus.byte_valid) begin
          shift_d = {shift_q[111:0], bus.byte_in};
          if (count_q == 5'd15) begin
            block_d = {shift_q, bus.byte_in};
            valid_d = 1'b1;
            count_d = 5'd16;
            state_d = StHold;
          end else begin
            count_d = count_q + 5'd1;
          end
        end
`ifdef SIPO_TIMEOUT_EN
        else if (count_q != 5'd0) begin
          if (idle_q == IdleLast) begin
            count_d   = 5'd0;
            shift_d   = '0;
            timeout_d = 1'b1;
          end else begin
            idle_d = idle_q + IdleW'(1);
          end
        end
`endif
      end
      StHold: begin
        if (valid_q && bus.block_ready) begin
          valid_d = 1'b0;
          state_d = StCollect;
          // A byte arriving with the handshake starts the next block.
          if (bus.byte_valid) begin
            shift_d = {shift_q[111:0], bus.byte_in};
            count_d = 5'd1;
          end else begin
            count_d = 5'd0;
          end
        end else if (bus.byte_valid) begin
          overrun_d = 1'b1;
        end
      end
      default: state_d = StCollect;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StCollect;
      shift_q   <= '0;
      block_q   <= '0;
      valid_q   <= 1'b0;
      count_q   <= 5'd0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      block_q   <= block_d;
      valid_q   <= valid_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
    end
  end

`ifdef SIPO_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      idle_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      idle_q    <= idle_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.timeout = timeout_q;
`else
  assign bus.timeout = 1'b0;
`endif

  assign bus.block_out   = block_q;
  assign bus.block_valid = valid_q;
  assign bus.byte_count  = count_q;
  assign bus.busy        = (state_q == StCollect) && (count_q != 5'd0);
  assign bus.overrun     = overrun_q;

endmodule

// File: tb/tb_sipo_block_assembler.sv
// Directed bench for sipo_block_assembler; expected blocks flow through a scoreboard queue.
module tb_sipo_block_assembler;

  logic clk = 1'b0;
  logic reset;
  sipo_block_assembler_if bus ();

  sipo_block_assembler #(.TIMEOUT_CYCLES(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [127:0] exp_q[$];
  logic [127:0] mdl_shift;
  int           mdl_count;
  logic [127:0] last_block;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one byte strobe while collecting; updates the model and scoreboard.
  task automatic send_byte(input logic [7:0] b);
    bus.byte_in    = b;
    bus.byte_valid = 1'b1;
    tick();
    bus.byte_valid = 1'b0;
    mdl_shift = {mdl_shift[119:0], b};
    mdl_count++;
    if (mdl_count == 16) exp_q.push_back(mdl_shift);
  endtask

  // Waits (bounded) for block_valid and checks block_out against the scoreboard head.
  task automatic expect_block(input string tag);
    int waited = 0;
    while (bus.block_valid !== 1'b1 && waited < 4) begin
      tick();
      waited++;
    end
    check({tag, "_valid"}, {127'd0, bus.block_valid}, 128'd1);
    check({tag, "_sb_nonempty"}, {127'd0, exp_q.size() > 0}, 128'd1);
    if (exp_q.size() > 0) begin
      last_block = exp_q.pop_front();
      check({tag, "_block"}, bus.block_out, last_block);
    end
  endtask

  // Handshake in HOLD, optionally with a byte riding along.
  task automatic accept(input logic with_byte, input logic [7:0] b);
    bus.block_ready = 1'b1;
    bus.byte_valid  = with_byte;
    bus.byte_in     = b;
    tick();
    bus.block_ready = 1'b0;
    bus.byte_valid  = 1'b0;
    mdl_shift = with_byte ? {mdl_shift[119:0], b} : mdl_shift;
    mdl_count = with_byte ? 1 : 0;
  endtask

  initial begin
    reset           = 1'b1;
    bus.byte_in     = 8'h00;
    bus.byte_valid  = 1'b0;
    bus.flush       = 1'b0;
    bus.block_ready = 1'b0;
    bus.clr_overrun = 1'b0;
    mdl_shift       = '0;
    mdl_count       = 0;
    last_block      = '0;
    tick();
    tick();
    reset = 1'b0;

    check("rst_valid", {127'd0, bus.block_valid}, 128'd0);
    check("rst_count", {123'd0, bus.byte_count}, 128'd0);
    check("rst_busy", {127'd0, bus.busy}, 128'd0);
    check("rst_overrun", {127'd0, bus.overrun}, 128'd0);
    check("rst_timeout", {127'd0, bus.timeout}, 128'd0);
    check("rst_block", bus.block_out, 128'd0);

    // Sixteen bytes 0x00..0x0F; valid must appear right after the 16th strobe.
    for (int i = 0; i < 15; i++) send_byte(8'(i));
    check("b15_valid_low", {127'd0, bus.block_valid}, 128'd0);
    check("b15_count", {123'd0, bus.byte_count}, 128'd15);
    check("b15_busy", {127'd0, bus.busy}, 128'd1);
    send_byte(8'h0F);
    check("b16_valid_now", {127'd0, bus.block_valid}, 128'd1);
    check("b16_count", {123'd0, bus.byte_count}, 128'd16);
    check("b16_busy", {127'd0, bus.busy}, 128'd0);
    check("b16_const", bus.block_out, 128'h000102030405060708090A0B0C0D0E0F);
    expect_block("blk0");

    // Flush is ignored in HOLD.
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    check("hold_flush_valid", {127'd0, bus.block_valid}, 128'd1);
    check("hold_flush_count", {123'd0, bus.byte_count}, 128'd16);

    accept(1'b0, 8'h00);
    check("hs_valid", {127'd0, bus.block_valid}, 128'd0);
    check("hs_count", {123'd0, bus.byte_count}, 128'd0);
    check("hs_block_kept", bus.block_out, last_block);

    // Overrun: byte in HOLD without ready is dropped.
    for (int i = 0; i < 16; i++) send_byte(8'(8'h10 + i));
    expect_block("blk1");
    bus.byte_in    = 8'hAA;
    bus.byte_valid = 1'b1;
    tick();
    bus.byte_valid = 1'b0;
    check("ovr_set", {127'd0, bus.overrun}, 128'd1);
    check("ovr_block_kept", bus.block_out, last_block);
    check("ovr_count", {123'd0, bus.byte_count}, 128'd16);
    // Set wins over clear in the same cycle.
    bus.byte_valid  = 1'b1;
    bus.clr_overrun = 1'b1;
    tick();
    bus.byte_valid = 1'b0;
    check("ovr_set_wins", {127'd0, bus.overrun}, 128'd1);
    tick();
    bus.clr_overrun = 1'b0;
    check("ovr_clr", {127'd0, bus.overrun}, 128'd0);

    // Handshake and byte together: byte becomes byte 0 of the next block.
    accept(1'b1, 8'h55);
    check("hsb_valid", {127'd0, bus.block_valid}, 128'd0);
    check("hsb_count", {123'd0, bus.byte_count}, 128'd1);
    check("hsb_overrun", {127'd0, bus.overrun}, 128'd0);
    check("hsb_busy", {127'd0, bus.busy}, 128'd1);
    for (int i = 1; i < 16; i++) send_byte(8'(i));
    check("hsb_msb", {120'd0, bus.block_out[127:120]}, 128'h55);
    expect_block("blk2");
    accept(1'b0, 8'h00);

    // Flush with a simultaneous byte drops the partial block and the byte.
    for (int i = 0; i < 5; i++) send_byte(8'(8'hC0 + i));
    bus.flush      = 1'b1;
    bus.byte_valid = 1'b1;
    bus.byte_in    = 8'hEE;
    tick();
    bus.flush      = 1'b0;
    bus.byte_valid = 1'b0;
    mdl_shift = '0;
    mdl_count = 0;
    check("flush_count", {123'd0, bus.byte_count}, 128'd0);
    check("flush_busy", {127'd0, bus.busy}, 128'd0);
    check("flush_block_kept", bus.block_out, last_block);
    for (int i = 0; i < 16; i++) send_byte(8'(8'hF0 + i));
    check("flush_new_const", bus.block_out, 128'hF0F1F2F3F4F5F6F7F8F9FAFBFCFDFEFF);
    expect_block("blk3");
    accept(1'b0, 8'h00);

    // Idle timeout on a partial block.
    for (int i = 0; i < 3; i++) send_byte(8'(8'hA0 + i));
`ifdef SIPO_TIMEOUT_EN
    for (int i = 0; i < 7; i++) tick();
    check("to_pre_pulse", {127'd0, bus.timeout}, 128'd0);
    check("to_pre_count", {123'd0, bus.byte_count}, 128'd3);
    tick();
    check("to_pulse", {127'd0, bus.timeout}, 128'd1);
    check("to_count", {123'd0, bus.byte_count}, 128'd0);
    tick();
    check("to_pulse_end", {127'd0, bus.timeout}, 128'd0);
    mdl_shift = '0;
    mdl_count = 0;
    for (int i = 0; i < 3; i++) send_byte(8'(8'hB0 + i));
    for (int i = 0; i < 7; i++) tick();
    send_byte(8'hB3);
    check("to_saved_pulse", {127'd0, bus.timeout}, 128'd0);
    check("to_saved_count", {123'd0, bus.byte_count}, 128'd4);
    tick();
    check("to_saved_later", {127'd0, bus.timeout}, 128'd0);
`else
    for (int i = 0; i < 20; i++) begin
      tick();
      check("noto_pulse", {127'd0, bus.timeout}, 128'd0);
    end
    check("noto_count", {123'd0, bus.byte_count}, 128'd3);
    check("noto_busy", {127'd0, bus.busy}, 128'd1);
`endif

    // Reset mid-block discards everything.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst2_count", {123'd0, bus.byte_count}, 128'd0);
    check("rst2_block", bus.block_out, 128'd0);
    check("sb_drained", 128'(exp_q.size()), 128'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed stuck expected finish");
    $fatal(1, "bench time limit exceeded");
  end

endmodule
